barker_frame_arbiter: RTL and testbench
=======================================

Name: barker_frame_arbiter

Overview:
- Frame-granular round-robin arbiter that shares the single 1-bit AXI-Stream input of the Barker correlator between N_SRC frame sources (test generators, live receivers).
- Holds a grant from the first beat of a frame through its tlast, so frames never interleave.
- Enforces a maximum frame length. Overlong frames are truncated at the correlator side and the remainder is drained from the source.
- Sits directly upstream of the correlator input port.

Parameters:
- N_SRC, 2, number of requesting sources (2..8).
- MAX_FRAME_LEN, 11, max beats per forwarded frame (Barker-11 length).
- CNT_W, 16, width of frame and error counters.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_enable  in  1  1 = new grants allowed; a frame already in progress always completes
- s_axis_tdata  in  N_SRC  bit k = data of source k
- s_axis_tvalid  in  N_SRC  per-source valid
- s_axis_tlast  in  N_SRC  per-source last
- s_axis_tready  out  N_SRC  per-source ready
- m_axis_tdata  out  1  data to correlator
- m_axis_tvalid  out  1  valid to correlator
- m_axis_tlast  out  1  last to correlator (source or forced)
- m_axis_tready  in  1  correlator ready
- m_axis_tid  out  $clog2(N_SRC) (min 1)  index of granted source
- o_frame_cnt  out  CNT_W  frames forwarded, wraps
- o_len_err  out  1  one-cycle pulse on truncation
- o_len_err_cnt  out  CNT_W  truncations, saturates at all-ones

Behaviour:
- Reset (synchronous, i_rst_n = 0 at posedge):
  - state = s_idle; grant = 0; last_grant = N_SRC-1, so source 0 has first priority; beat_cnt = 0.
  - Counters = 0; o_len_err = 0.
  - During and after reset: all s_axis_tready = 0, m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0, m_axis_tid = 0.
  - Reset mid-frame abandons the frame immediately, with no drain.
- State machine, registered, enum arb_state_t = {s_idle, s_pass, s_drain}.
- s_idle:
  - All s_axis_tready = 0; m_axis_tvalid = 0.
  - If i_enable and any s_axis_tvalid: grant = first requester searching upward from last_grant+1 (mod N_SRC).
  - On that edge: last_grant = grant, beat_cnt = 0, go to s_pass.
  - Arbitration latency: 1 cycle from tvalid to first possible beat.
- s_pass, combinational pass-through with zero latency:
  - m_axis_tdata = s_axis_tdata[grant]; m_axis_tvalid = s_axis_tvalid[grant]; m_axis_tid = grant.
  - s_axis_tready[grant] = m_axis_tready; all other readies = 0.
  - Beat = m_axis_tvalid & m_axis_tready; beat_cnt increments on each beat.
  - m_axis_tlast = s_axis_tlast[grant] | (beat_cnt == MAX_FRAME_LEN-1).
  - Beat with s_axis_tlast[grant] = 1: o_frame_cnt++, go to s_idle. This leaves a one-cycle bubble between frames.
  - Beat with beat_cnt == MAX_FRAME_LEN-1 and source tlast = 0: forced tlast, o_frame_cnt++, o_len_err pulses the next cycle, o_len_err_cnt++ (saturating), go to s_drain.
  - If source tlast and the length limit coincide on the same beat: normal end, no error.
  - i_enable deasserted in s_pass has no effect.
  - Source tvalid dropping mid-frame: the grant is held indefinitely (no timeout).
- s_drain:
  - m_axis_tvalid = 0; s_axis_tready[grant] = 1; other readies = 0.
  - Granted-source beats are discarded.
  - Discarded beat with tlast: go to s_idle.
- Fairness: after source k completes a frame, any other pending source is served before k again.
- Outputs m_axis_* are combinational from registered grant/state and the source inputs. No combinational path from m_axis_tready to m_axis_tvalid.
- Width rules:
  - beat_cnt width = $clog2(MAX_FRAME_LEN+1).
  - o_frame_cnt wraps at 2^CNT_W.
  - o_len_err_cnt saturates at 2^CNT_W-1.

Decomposition:
- barker_pkg holds:
  - BARKER_LEN = 11.
  - GOLDEN_SEQ = 11'b11100010010.
  - typedef arb_state_t.
- Sub-module rr_pick (combinational):
  - Inputs: req[N_SRC], last_grant.
  - Outputs: grant index, any_req.
  - Instantiated once; the FSM, counters and stream mux stay in barker_frame_arbiter.

Test Plan:
- Single source, 11-beat frame of GOLDEN_SEQ, m_axis_tready = 1 -> first beat 1 cycle after tvalid, 11 beats MSB-first, tlast on beat 11, o_frame_cnt = 1, m_axis_tid = 0.
- Sources 0 and 1 both continuously valid, 4 frames each -> forwarded order tid 0,1,0,1,...; no interleaving; exactly one idle cycle between frames; o_frame_cnt = 8.
- m_axis_tready toggled randomly 50% mid-frame -> every source beat forwarded exactly once, in order; non-granted source sees tready = 0 throughout.
- Source 1 sends a 14-beat frame -> forwarded 11 beats with tlast forced on beat 11; last 3 beats drained with m_axis_tvalid = 0; o_len_err pulses once; o_len_err_cnt = 1; next grant goes to source 0 if pending.
- i_enable = 0 with both sources valid -> no grants, all readies 0; i_enable dropped mid-frame -> that frame completes, then idle.
- Assert i_rst_n = 0 at beat 5 of a frame -> next cycle all readies 0, m_axis_tvalid = 0, counters 0; after release, source 0 is granted first.

Source files
------------

// File: rtl/barker_pkg.sv
// Shared definitions for the Barker correlator front end.
//   BARKER_LEN  : length of the Barker-11 code, default frame length limit
//   GOLDEN_SEQ  : reference Barker-11 pattern, MSB transmitted first
//   arb_state_t : frame arbiter state encoding
package barker_pkg;

   localparam int unsigned               BARKER_LEN = 11;
   localparam logic [BARKER_LEN-1:0]     GOLDEN_SEQ = 11'b11100010010;

   typedef enum logic [1:0] {
      s_idle,
      s_pass,
      s_drain
   } arb_state_t;

endpackage

// File: rtl/barker_frame_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req        : per-source request vector
//   last_grant : index of the most recently granted source
//   grant      : first requester found searching upward from last_grant+1
//   any_req    : at least one request present
module rr_pick
   import barker_pkg::*;
#(
   parameter int unsigned N_SRC = 2,
   parameter int unsigned GW    = 1
) (
   input  logic [N_SRC-1:0] req,
   input  logic [GW-1:0]    last_grant,
   output logic [GW-1:0]    grant,
   output logic             any_req
);

   int unsigned idx;

   // Walk offsets from farthest to nearest so the nearest requester
   // after last_grant is the final (winning) assignment.
   always_comb begin
      grant   = '0;
      any_req = 1'b0;
      idx     = 0;
      for (int unsigned off = N_SRC; off > 0; off--) begin
         idx = (32'(last_grant) + off) % N_SRC;
         if (req[idx]) begin
            grant   = GW'(idx);
            any_req = 1'b1;
         end
      end
   end

endmodule

// File: rtl/barker_frame_arbiter.sv
// Frame-granular round-robin arbiter feeding the 1-bit Barker correlator
// input. A grant is held from the first beat of a frame through its tlast;
// frames longer than MAX_FRAME_LEN are cut with a forced tlast and the
// remainder is drained from the source.
//   i_clk, i_rst_n   : clock, synchronous active-low reset
//   i_enable         : allows new grants; a frame in progress always completes
//   s_axis_*         : N_SRC source streams (bit k belongs to source k)
//   m_axis_*         : stream to correlator, m_axis_tid = granted source
//   o_frame_cnt      : frames forwarded (wraps)
//   o_len_err        : one-cycle pulse after a truncation
//   o_len_err_cnt    : truncations (saturates)
module barker_frame_arbiter
   import barker_pkg::*;
#(
   parameter int unsigned  N_SRC         = 2,
   parameter int unsigned  MAX_FRAME_LEN = BARKER_LEN,
   parameter int unsigned  CNT_W         = 16,
   localparam int unsigned GW            = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_enable,
   input  logic [N_SRC-1:0] s_axis_tdata,
   input  logic [N_SRC-1:0] s_axis_tvalid,
   input  logic [N_SRC-1:0] s_axis_tlast,
   output logic [N_SRC-1:0] s_axis_tready,
   output logic             m_axis_tdata,
   output logic             m_axis_tvalid,
   output logic             m_axis_tlast,
   input  logic             m_axis_tready,
   output logic [GW-1:0]    m_axis_tid,
   output logic [CNT_W-1:0] o_frame_cnt,
   output logic             o_len_err,
   output logic [CNT_W-1:0] o_len_err_cnt
);

   localparam int unsigned      BW        = $clog2(MAX_FRAME_LEN + 1);
   localparam logic [BW-1:0]    BEAT_LAST = BW'(MAX_FRAME_LEN - 1);
   localparam logic [BW-1:0]    BEAT_ONE  = BW'(1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   arb_state_t    state, state_n;
   logic [GW-1:0] grant, last_grant, pick;
   logic [BW-1:0] beat_cnt;
   logic          any_req;
   logic          beat, at_limit, src_last;

   rr_pick #(
      .N_SRC (N_SRC),
      .GW    (GW)
   ) u_rr_pick (
      .req        (s_axis_tvalid),
      .last_grant (last_grant),
      .grant      (pick),
      .any_req    (any_req)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) state <= s_idle;
      else          state <= state_n;
   end

   // Outputs are forced quiet while reset is held so an abandoned frame
   // cannot complete a handshake during the reset cycle.
   always_comb begin
      state_n       = state;
      s_axis_tready = '0;
      m_axis_tdata  = 1'b0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      m_axis_tid    = '0;
      beat          = 1'b0;
      at_limit      = (beat_cnt == BEAT_LAST);
      src_last      = s_axis_tlast[grant];
      if (i_rst_n) begin
         unique case (state)
            s_idle: begin
               if (i_enable && any_req) state_n = s_pass;
            end
            s_pass: begin
               m_axis_tdata         = s_axis_tdata[grant];
               m_axis_tvalid        = s_axis_tvalid[grant];
               m_axis_tlast         = src_last | at_limit;
               m_axis_tid           = grant;
               s_axis_tready[grant] = m_axis_tready;
               beat                 = s_axis_tvalid[grant] & m_axis_tready;
               if (beat && src_last)      state_n = s_idle;
               else if (beat && at_limit) state_n = s_drain;
            end
            s_drain: begin
               s_axis_tready[grant] = 1'b1;
               if (s_axis_tvalid[grant] && src_last) state_n = s_idle;
            end
            default: state_n = s_idle;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         grant         <= '0;
         last_grant    <= GW'(N_SRC - 1);
         beat_cnt      <= '0;
         o_frame_cnt   <= '0;
         o_len_err     <= 1'b0;
         o_len_err_cnt <= '0;
      end else begin
         o_len_err <= 1'b0;
         case (state)
            s_idle: begin
               if (i_enable && any_req) begin
                  grant      <= pick;
                  last_grant <= pick;
                  beat_cnt   <= '0;
               end
            end
            s_pass: begin
               if (beat) begin
                  beat_cnt <= beat_cnt + BEAT_ONE;
                  if (src_last || at_limit) o_frame_cnt <= o_frame_cnt + CNT_ONE;
                  // A source tlast on the limit beat is a normal end.
                  if (!src_last && at_limit) begin
                     o_len_err <= 1'b1;
                     if (o_len_err_cnt != '1) o_len_err_cnt <= o_len_err_cnt + CNT_ONE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_barker_frame_arbiter.sv
module tb_barker_frame_arbiter;
   import barker_pkg::*;

   localparam int N    = 2;
   localparam int MAXL = 11;
   localparam int CW   = 16;

   logic          clk = 1'b0;
   logic          rst_n, en;
   logic [N-1:0]  s_tdata, s_tvalid, s_tlast, s_tready;
   logic          m_tdata, m_tvalid, m_tlast, m_tready;
   logic [0:0]    m_tid;
   logic [CW-1:0] frame_cnt, err_cnt;
   logic          len_err;

   always #5 clk = ~clk;

   barker_frame_arbiter #(
      .N_SRC         (N),
      .MAX_FRAME_LEN (MAXL),
      .CNT_W         (CW)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_enable      (en),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tlast  (s_tlast),
      .s_axis_tready (s_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tlast  (m_tlast),
      .m_axis_tready (m_tready),
      .m_axis_tid    (m_tid),
      .o_frame_cnt   (frame_cnt),
      .o_len_err     (len_err),
      .o_len_err_cnt (err_cnt)
   );

   typedef struct packed { logic d; logic l; } sbeat_t;
   typedef struct packed { logic [7:0] tid; logic d; logic l; logic [31:0] cyc; } obeat_t;

   sbeat_t srcq [N][$];
   obeat_t outlog[$];
   obeat_t expq[$];

   int   checks = 0, errors = 0, cyc = 0, err_pulses = 0;
   bit   mon_on = 0;
   logic rand_ready = 1'b0, ready_lvl = 1'b1;
   int   rise [N];
   logic [N-1:0] prev_v = '0;

   // behavioural model state: owner -1 means nobody holds the stream
   int m_owner = -1, m_last = N - 1, m_nb = 0, m_frames = 0, m_errs = 0;
   bit m_drain = 0, m_pulse = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic push_frame(input int k, input logic [31:0] bits, input int len);
      sbeat_t b;
      for (int i = len - 1; i >= 0; i--) begin
         b.d = bits[i];
         b.l = (i == 0);
         srcq[k].push_back(b);
      end
   endtask

   // expected forwarded beats of one frame, including the forced cut
   task automatic expect_frame(input int tid, input logic [31:0] bits, input int len);
      obeat_t o;
      for (int j = 0; j < len && j < MAXL; j++) begin
         o.tid = 8'(tid);
         o.d   = bits[len - 1 - j];
         o.l   = (j == len - 1) || (j == MAXL - 1);
         o.cyc = '0;
         expq.push_back(o);
      end
   endtask

   task automatic wait_beats(input int n, input int budget, input string nm);
      int b = 0;
      while (outlog.size() < n && b < budget) begin
         tick();
         b++;
      end
      if (outlog.size() < n) begin
         checks++;
         errors++;
         $display("FAIL %s timeout beats=%0d required=%0d", nm, outlog.size(), n);
      end
   endtask

   task automatic compare_stream(input string nm);
      chk({nm, "_len"}, outlog.size(), expq.size());
      for (int i = 0; i < expq.size() && i < outlog.size(); i++)
         chk($sformatf("%s_beat%0d", nm, i),
             {outlog[i].tid, outlog[i].d, outlog[i].l},
             {expq[i].tid, expq[i].d, expq[i].l});
   endtask

   // source driver: presents the head of each queue after every edge
   always @(posedge clk) begin
      #3;
      for (int k = 0; k < N; k++) begin
         if (srcq[k].size() > 0) begin
            s_tvalid[k] = 1'b1;
            s_tdata[k]  = srcq[k][0].d;
            s_tlast[k]  = srcq[k][0].l;
         end else begin
            s_tvalid[k] = 1'b0;
            s_tdata[k]  = 1'b0;
            s_tlast[k]  = 1'b0;
         end
      end
      m_tready = rand_ready ? 1'($urandom_range(0, 1)) : ready_lvl;
   end

   // compare process: mid-cycle check against the model, then advance it
   always @(negedge clk) begin : mon
      logic [N-1:0] e_rdy;
      logic         e_v, e_d, e_l;
      int           e_id, nxt;
      bit           cmp_side;
      obeat_t       o;
      if (mon_on) begin
         cyc++;
         e_rdy = '0; e_v = 0; e_d = 0; e_l = 0; e_id = 0; cmp_side = 1;
         if (rst_n && m_owner >= 0) begin
            if (m_drain) begin
               e_rdy[m_owner] = 1'b1;
               cmp_side = 0;
            end else begin
               e_rdy[m_owner] = m_tready;
               e_v  = s_tvalid[m_owner];
               e_d  = s_tdata[m_owner];
               e_l  = s_tlast[m_owner] || (m_nb == MAXL - 1);
               e_id = m_owner;
               cmp_side = e_v;
            end
         end
         chk("s_tready", s_tready, e_rdy);
         chk("m_tvalid", m_tvalid, e_v);
         if (cmp_side) begin
            chk("m_tdata", m_tdata, e_d);
            chk("m_tlast", m_tlast, e_l);
            chk("m_tid", m_tid, e_id);
         end
         chk("frame_cnt", frame_cnt, m_frames % 65536);
         chk("len_err_cnt", err_cnt, m_errs);
         chk("len_err", len_err, m_pulse);

         if (m_tvalid && m_tready) begin
            o.tid = 8'(m_tid); o.d = m_tdata; o.l = m_tlast; o.cyc = cyc;
            outlog.push_back(o);
         end
         for (int k = 0; k < N; k++) begin
            if (s_tvalid[k] && !prev_v[k]) rise[k] = cyc;
            if (s_tvalid[k] && s_tready[k] && srcq[k].size() > 0) void'(srcq[k].pop_front());
         end
         prev_v = s_tvalid;
         if (len_err) err_pulses++;

         if (!rst_n) begin
            m_owner = -1; m_last = N - 1; m_nb = 0; m_drain = 0;
            m_frames = 0; m_errs = 0; m_pulse = 0;
         end else begin
            m_pulse = 0;
            if (m_owner < 0) begin
               nxt = -1;
               for (int i = 1; i <= N; i++)
                  if (nxt < 0 && s_tvalid[(m_last + i) % N]) nxt = (m_last + i) % N;
               if (en && nxt >= 0) begin
                  m_owner = nxt; m_last = nxt; m_nb = 0; m_drain = 0;
               end
            end else if (m_drain) begin
               if (s_tvalid[m_owner] && s_tlast[m_owner]) begin
                  m_owner = -1; m_drain = 0;
               end
            end else if (s_tvalid[m_owner] && m_tready) begin
               m_nb++;
               if (s_tlast[m_owner]) begin
                  m_frames++; m_owner = -1;
               end else if (m_nb == MAXL) begin
                  m_frames++; m_pulse = 1; m_drain = 1;
                  if (m_errs < 65535) m_errs++;
               end
            end
         end
      end
   end

   initial begin : stim
      logic [10:0] word_d, word_l;
      int          tid_or, starts;
      logic [7:0]  first_tid [8];
      int          pulses0;

      rst_n = 1'b0; en = 1'b0; m_tready = 1'b1;
      s_tdata = '0; s_tvalid = '0; s_tlast = '0;
      @(posedge clk);
      mon_on = 1;
      repeat (3) tick();

      // reset state
      chk("rst_tready", s_tready, 0);
      chk("rst_tvalid", m_tvalid, 0);
      chk("rst_tlast", m_tlast, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_err_cnt", err_cnt, 0);
      rst_n = 1'b1; en = 1'b1;
      tick();

      // single source, golden Barker-11 frame
      push_frame(0, 32'(GOLDEN_SEQ), 11);
      wait_beats(11, 60, "t1_wait");
      tick();
      word_d = '0; word_l = '0; tid_or = 0;
      for (int i = 0; i < 11 && i < outlog.size(); i++) begin
         word_d = {word_d[9:0], outlog[i].d};
         word_l = {word_l[9:0], outlog[i].l};
         tid_or = tid_or | int'(outlog[i].tid);
      end
      chk("t1_data", word_d, 11'b11100010010);
      chk("t1_tlast_pos", word_l, 11'b00000000001);
      chk("t1_tid", tid_or, 0);
      if (outlog.size() > 0) chk("t1_latency", outlog[0].cyc - rise[0], 1);
      chk("t1_frame_cnt", frame_cnt, 1);
      chk("t1_err_cnt", err_cnt, 0);

      // both sources continuously valid, 4 frames each; source 0 went last
      outlog.delete(); expq.delete();
      push_frame(0, 32'b101, 3);    push_frame(0, 32'b1100, 4);
      push_frame(0, 32'b10011, 5);  push_frame(0, 32'b111000, 6);
      push_frame(1, 32'b010110, 6); push_frame(1, 32'b01101, 5);
      push_frame(1, 32'b0011, 4);   push_frame(1, 32'b110, 3);
      expect_frame(1, 32'b010110, 6); expect_frame(0, 32'b101, 3);
      expect_frame(1, 32'b01101, 5);  expect_frame(0, 32'b1100, 4);
      expect_frame(1, 32'b0011, 4);   expect_frame(0, 32'b10011, 5);
      expect_frame(1, 32'b110, 3);    expect_frame(0, 32'b111000, 6);
      wait_beats(36, 200, "t2_wait");
      tick();
      compare_stream("t2");
      starts = 0;
      for (int i = 0; i < outlog.size(); i++) begin
         if ((i == 0 || outlog[i-1].l) && starts < 8) begin
            first_tid[starts] = outlog[i].tid;
            starts++;
         end
         if (i > 0 && outlog[i-1].l)
            chk($sformatf("t2_gap%0d", i), outlog[i].cyc - outlog[i-1].cyc, 2);
      end
      chk("t2_frames", starts, 8);
      chk("t2_tid_order", {first_tid[0][0], first_tid[1][0], first_tid[2][0], first_tid[3][0],
                           first_tid[4][0], first_tid[5][0], first_tid[6][0], first_tid[7][0]},
          8'b10101010);
      chk("t2_frame_cnt", frame_cnt, 9);

      // random back-pressure mid-frame
      outlog.delete(); expq.delete();
      rand_ready = 1'b1;
      push_frame(0, 32'b1011001, 7);
      push_frame(1, 32'b11010, 5);
      expect_frame(1, 32'b11010, 5);
      expect_frame(0, 32'b1011001, 7);
      wait_beats(12, 300, "t3_wait");
      rand_ready = 1'b0;
      tick();
      compare_stream("t3");
      chk("t3_frame_cnt", frame_cnt, 11);

      // overlong frame from source 1, source 0 pending behind it
      outlog.delete(); expq.delete();
      pulses0 = err_pulses;
      push_frame(1, 32'b10110011100011, 14);
      push_frame(0, 32'b011, 3);
      expect_frame(1, 32'b10110011100011, 14);
      expect_frame(0, 32'b011, 3);
      wait_beats(14, 200, "t4_wait");
      repeat (2) tick();
      compare_stream("t4");
      chk("t4_err_pulses", err_pulses - pulses0, 1);
      chk("t4_err_cnt", err_cnt, 1);
      chk("t4_frame_cnt", frame_cnt, 13);
      chk("t4_drained", srcq[1].size(), 0);

      // enable low blocks grants; dropping it mid-frame lets the frame finish
      outlog.delete(); expq.delete();
      en = 1'b0;
      push_frame(0, 32'b10010110, 8);
      push_frame(1, 32'b111001, 6);
      repeat (10) tick();
      chk("t5_no_beats", outlog.size(), 0);
      chk("t5_q0_held", srcq[0].size(), 8);
      chk("t5_q1_held", srcq[1].size(), 6);
      en = 1'b1;
      wait_beats(1, 20, "t5_start");
      en = 1'b0;
      wait_beats(6, 40, "t5_wait");
      repeat (10) tick();
      expect_frame(1, 32'b111001, 6);
      compare_stream("t5");
      chk("t5_q0_after", srcq[0].size(), 8);

      // reset during beat 5 of source 0's frame
      outlog.delete(); expq.delete();
      en = 1'b1;
      wait_beats(4, 40, "t6_wait");
      rst_n = 1'b0;
      srcq[0].delete(); srcq[1].delete();
      tick();
      chk("t6_rst_tready", s_tready, 0);
      chk("t6_rst_tvalid", m_tvalid, 0);
      chk("t6_rst_frame_cnt", frame_cnt, 0);
      chk("t6_rst_err_cnt", err_cnt, 0);
      tick();
      rst_n = 1'b1;
      outlog.delete();
      push_frame(1, 32'b101, 3);
      push_frame(0, 32'b110, 3);
      expect_frame(0, 32'b110, 3);
      expect_frame(1, 32'b101, 3);
      wait_beats(6, 60, "t6_after");
      tick();
      if (outlog.size() > 0) chk("t6_first_tid", outlog[0].tid, 0);
      compare_stream("t6");
      chk("t6_frame_cnt", frame_cnt, 2);

      repeat (3) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout reached");
      $fatal(1, "timeout");
   end

endmodule
